// File: rtl/core_pkg.sv
// Shared types and bus addresses for the core_oamdma sprite DMA block.
// Holds the DMA FSM state encoding and the trigger/destination addresses.
package core_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PEND,
        ALIGN,
        READ,
        WRITE
    } dma_state_t;

    localparam logic [15:0] ADDR_OAMDMA  = 16'h4014;
    localparam logic [15:0] ADDR_OAMDATA = 16'h2004;

endpackage

// File: rtl/core_oamdma_if.sv
// Bus bundle between the CPU side, the system bus and core_oamdma.
// The slave modport is the DMA block's view; master is the driver's view.
interface core_oamdma_if;

    logic        I_ready;
    logic [15:0] I_cpu_addr;
    logic [7:0]  I_cpu_wr_data;
    logic        I_cpu_rdwr;
    logic        I_cpu_sync;
    logic        O_cpu_ready;
    logic [7:0]  I_rd_data;
    logic [15:0] O_addr;
    logic [7:0]  O_wr_data;
    logic        O_rdwr;
    logic        O_sync;
    logic        O_dma_active;

    modport slave (
        input  I_ready, I_cpu_addr, I_cpu_wr_data, I_cpu_rdwr,
        input  I_cpu_sync, I_rd_data,
        output O_cpu_ready, O_addr, O_wr_data, O_rdwr,
        output O_sync, O_dma_active
    );

    modport master (
        output I_ready, I_cpu_addr, I_cpu_wr_data, I_cpu_rdwr,
        output I_cpu_sync, I_rd_data,
        input  O_cpu_ready, O_addr, O_wr_data, O_rdwr,
        input  O_sync, O_dma_active
    );

endinterface

// File: rtl/core_oamdma.sv
// Sprite (OAM) DMA controller and CPU/system bus arbiter.
// CORE_OAMDMA_ALIGN_EN adds the parity register and the ALIGN cycle.
module core_oamdma
    import core_pkg::*;
#(
    parameter logic [15:0] P_TRIGGER_ADDR = ADDR_OAMDMA,
    parameter logic [15:0] P_DEST_ADDR    = ADDR_OAMDATA
) (
    input  logic          I_clock,
    input  logic          I_reset,
    core_oamdma_if.slave  bus
);

    dma_state_t r_state;
    dma_state_t w_state_nx;
    logic [7:0] r_idx;
    logic [7:0] r_page;
    logic [7:0] r_latch;
    logic       w_trig;
    logic       w_halt;

    assign w_trig = bus.I_ready & ~bus.I_cpu_rdwr &
                    (bus.I_cpu_addr == P_TRIGGER_ADDR);

`ifdef CORE_OAMDMA_ALIGN_EN
    logic r_parity;

    always_ff @(posedge I_clock) begin
        if (!I_reset) begin
            r_parity <= 1'b0;
        end else if (bus.I_ready) begin
            r_parity <= ~r_parity;
        end
    end
`endif

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_trig) w_state_nx = PEND;
            end
            PEND: begin
                // 6502 RDY only stops the CPU on a read cycle
                if (bus.I_ready & bus.I_cpu_rdwr) begin
`ifdef CORE_OAMDMA_ALIGN_EN
                    w_state_nx = r_parity ? READ : ALIGN;
`else
                    w_state_nx = READ;
`endif
                end
            end
            ALIGN: begin
                if (bus.I_ready) w_state_nx = READ;
            end
            READ: begin
                if (bus.I_ready) w_state_nx = WRITE;
            end
            WRITE: begin
                if (bus.I_ready) begin
                    w_state_nx = (r_idx == 8'hFF) ? IDLE : READ;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge I_clock) begin
        if (!I_reset) begin
            r_state <= IDLE;
            r_idx   <= 8'h00;
            r_page  <= 8'h00;
            r_latch <= 8'h00;
        end else if (bus.I_ready) begin
            r_state <= w_state_nx;
            if ((r_state == IDLE) && w_trig) r_page <= bus.I_cpu_wr_data;
            if (r_state == READ) r_latch <= bus.I_rd_data;
            if (r_state == WRITE) r_idx <= r_idx + 8'h01;
        end
    end

    always_comb begin
        w_halt = 1'b0;
        unique case (r_state)
            PEND:               w_halt = bus.I_cpu_rdwr;
            ALIGN, READ, WRITE: w_halt = 1'b1;
            default:            w_halt = 1'b0;
        endcase
        // reset aborts at once, so the bus goes back to the CPU this cycle
        if (!I_reset) w_halt = 1'b0;
    end

    always_comb begin
        bus.O_addr    = bus.I_cpu_addr;
        bus.O_wr_data = bus.I_cpu_wr_data;
        bus.O_rdwr    = bus.I_cpu_rdwr;
        if (I_reset) begin
            unique case (r_state)
                ALIGN: bus.O_rdwr = 1'b1;
                READ: begin
                    bus.O_addr = {r_page, r_idx};
                    bus.O_rdwr = 1'b1;
                end
                WRITE: begin
                    bus.O_addr    = P_DEST_ADDR;
                    bus.O_wr_data = r_latch;
                    bus.O_rdwr    = 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.O_cpu_ready  = bus.I_ready & ~w_halt;
    assign bus.O_sync       = bus.I_cpu_sync & ~w_halt;
    assign bus.O_dma_active = w_halt;

endmodule

// File: tb/tb_core_oamdma.sv
// Directed testbench for core_oamdma: pass-through vector table plus
// full-transfer sequences (parity, pushes, stall, reset abort, re-trigger).
module tb_core_oamdma;
    import core_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic par;
    int   errs = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    core_oamdma_if bus ();

    core_oamdma dut (
        .I_clock (clk),
        .I_reset (rst_n),
        .bus     (bus)
    );

    // reference parity: toggles on every ready clock, cleared by reset
    always @(posedge clk) begin
        if (!rst_n) par <= 1'b0;
        else if (bus.I_ready) par <= ~par;
    end

    function automatic logic [7:0] memf(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    always_comb bus.I_rd_data = memf(bus.O_addr);

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cpu(input logic [15:0] a, input logic [7:0] d,
                       input logic rw, input logic sy, input logic rdy);
        bus.I_cpu_addr    = a;
        bus.I_cpu_wr_data = d;
        bus.I_cpu_rdwr    = rw;
        bus.I_cpu_sync    = sy;
        bus.I_ready       = rdy;
    endtask

    function automatic logic [31:0] obs();
        return {bus.O_addr, bus.O_wr_data, bus.O_rdwr, bus.O_sync,
                bus.O_cpu_ready, bus.O_dma_active};
    endfunction

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        logic        rw;
        logic        sy;
        logic        rdy;
        logic [31:0] exp;
    } vec_t;

    task automatic do_dma(input string tag, input logic [7:0] page,
                          input int npush, input logic want_par,
                          input int stall_idx, input int inject_idx,
                          input int abort_idx);
        logic [15:0] ca;
        logic [7:0]  eidx;
        int halted, lowcyc, dummies, pairs, rerr, werr, stall_left;
        int exp_halt, align;
        bit started, done, stalled, injected;
        ca = 16'h8123;
        eidx = 8'h00;
        halted = 0; lowcyc = 0; dummies = 0; pairs = 0;
        rerr = 0; werr = 0; stall_left = 0;
        started = 0; done = 0; stalled = 0; injected = 0;
`ifdef CORE_OAMDMA_ALIGN_EN
        align = want_par ? 0 : 1;
`else
        align = 0;
`endif
        exp_halt = 513 + align;
        @(negedge clk);
        if ((par ^ ~npush[0]) != want_par) begin
            cpu(16'h8000, 8'h00, 1'b1, 1'b0, 1'b1);
            @(negedge clk);
        end
        cpu(ADDR_OAMDMA, page, 1'b0, 1'b0, 1'b1);
        #1;
        chk({tag, " trigger"}, {bus.O_addr, 5'd0, bus.O_rdwr,
            bus.O_cpu_ready, bus.O_dma_active},
            {ADDR_OAMDMA, 5'd0, 1'b0, 1'b1, 1'b0});
        for (int i = 0; i < npush; i++) begin
            @(negedge clk);
            cpu(16'h01FF - 16'(i), 8'(i), 1'b0, 1'b0, 1'b1);
            #1;
            chk({tag, " push"}, {bus.O_addr, bus.O_rdwr,
                bus.O_cpu_ready, bus.O_dma_active},
                {16'h01FF - 16'(i), 1'b0, 1'b1, 1'b0});
        end
        for (int cyc = 0; cyc < 800 && !done; cyc++) begin
            @(negedge clk);
            if (inject_idx >= 0 && !injected && started &&
                eidx == 8'(inject_idx)) begin
                cpu(ADDR_OAMDMA, 8'h07, 1'b0, 1'b0, 1'b1);
                injected = 1;
            end else begin
                cpu(ca, 8'h00, 1'b1, 1'b0, 1'b1);
            end
            if (stall_left > 0) begin
                bus.I_ready = 1'b0;
                stall_left--;
            end
            #1;
            if (stall_idx >= 0 && !stalled && bus.I_ready &&
                bus.O_rdwr && bus.O_addr == {page, 8'(stall_idx)}) begin
                bus.I_ready = 1'b0;
                stalled = 1;
                stall_left = 4;
                #1;
            end
            if (stalled && !bus.I_ready) begin
                chk({tag, " stall hold"}, {bus.O_addr, bus.O_rdwr,
                    bus.O_cpu_ready}, {page, 8'(stall_idx), 1'b1, 1'b0});
            end
            if (abort_idx >= 0 && bus.I_ready && bus.O_dma_active &&
                bus.O_rdwr && bus.O_addr == {page, 8'(abort_idx)}) begin
                chk({tag, " pairs before abort"}, pairs, abort_idx);
                rst_n = 1'b0;
                #1;
                chk({tag, " in reset"}, {bus.O_addr, bus.O_rdwr,
                    bus.O_cpu_ready, bus.O_dma_active},
                    {ca, 1'b1, 1'b1, 1'b0});
                @(negedge clk);
                rst_n = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    #1;
                    chk({tag, " after abort"}, {bus.O_addr, bus.O_rdwr,
                        bus.O_cpu_ready, bus.O_dma_active},
                        {ca, 1'b1, 1'b1, 1'b0});
                    @(negedge clk);
                end
                return;
            end
            if (!bus.O_cpu_ready) lowcyc++;
            if (bus.I_ready) begin
                if (!bus.O_cpu_ready) begin
                    halted++;
                    started = 1;
                    if (bus.O_rdwr && bus.O_addr == bus.I_cpu_addr) begin
                        dummies++;
                    end else if (bus.O_rdwr) begin
                        if (bus.O_addr !== {page, eidx}) rerr++;
                    end else begin
                        if (bus.O_addr !== ADDR_OAMDATA ||
                            bus.O_wr_data !== memf({page, eidx})) werr++;
                        eidx++;
                        pairs++;
                    end
                end else if (started) begin
                    done = 1;
                    chk({tag, " cpu resumes"}, {bus.O_addr, bus.O_rdwr,
                        bus.O_dma_active}, {ca, 1'b1, 1'b0});
                end
            end
        end
        chk({tag, " completed"}, done, 1);
        chk({tag, " halted cycles"}, halted, exp_halt);
        chk({tag, " pairs"}, pairs, 256);
        chk({tag, " read addr errs"}, rerr, 0);
        chk({tag, " write errs"}, werr, 0);
        chk({tag, " dummy reads"}, dummies, 1 + align);
        if (stall_idx >= 0) begin
            chk({tag, " low cycles"}, lowcyc, exp_halt + 5);
        end
    endtask

    vec_t vt[8];

    initial begin
        vt[0] = '{16'h8000, 8'h00, 1'b1, 1'b1, 1'b1,
                  {16'h8000, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0}};
        vt[1] = '{16'h0100, 8'h33, 1'b0, 1'b0, 1'b1,
                  {16'h0100, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0}};
        vt[2] = '{16'h1234, 8'h00, 1'b1, 1'b1, 1'b0,
                  {16'h1234, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0}};
        vt[3] = '{16'h4014, 8'h09, 1'b0, 1'b0, 1'b0,
                  {16'h4014, 8'h09, 1'b0, 1'b0, 1'b0, 1'b0}};
        vt[4] = '{16'hFFFC, 8'h00, 1'b1, 1'b0, 1'b1,
                  {16'hFFFC, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0}};
        vt[5] = '{16'h4015, 8'h02, 1'b0, 1'b0, 1'b1,
                  {16'h4015, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0}};
        vt[6] = '{16'h4014, 8'h5A, 1'b1, 1'b1, 1'b1,
                  {16'h4014, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b0}};
        vt[7] = '{16'h0000, 8'h00, 1'b1, 1'b0, 1'b1,
                  {16'h0000, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0}};

        cpu(16'h1111, 8'h44, 1'b1, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        #1;
        chk("reset passthru", obs(),
            {16'h1111, 8'h44, 1'b1, 1'b1, 1'b1, 1'b0});
        bus.I_ready = 1'b0;
        #1;
        chk("reset ready0", obs(),
            {16'h1111, 8'h44, 1'b1, 1'b1, 1'b0, 1'b0});
        bus.I_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            cpu(vt[i].a, vt[i].d, vt[i].rw, vt[i].sy, vt[i].rdy);
            #1;
            chk($sformatf("idle vec %0d", i), obs(), vt[i].exp);
        end

        do_dma("even", 8'h02, 0, 1'b1, -1, -1, -1);
        do_dma("odd", 8'h02, 0, 1'b0, -1, -1, -1);
        do_dma("push", 8'hFF, 3, 1'b1, -1, -1, -1);
        do_dma("stall", 8'h02, 0, 1'b1, 8'h40, -1, -1);
        do_dma("abort", 8'h02, 0, 1'b1, -1, -1, 8'h80);
        do_dma("retrig", 8'h02, 0, 1'b1, -1, 8'h10, -1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
